// File: rtl/chain_eval_sched.sv
// chain_eval_sched: round-robin front end that time-shares one multicycle
// chain evaluator between NUM_REQ requesters. It owns the operand register
// feeding the chain, waits SETTLE_CYCLES for the result, and returns it
// tagged with the requester ID.
module chain_eval_sched #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         eval_operand,
  input  logic                      eval_result,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_result,
  input  logic                      rsp_ready,
  output logic                      busy,
  output logic [CNT_W-1:0]          done_count
);

  // Settle counter only has to hold SETTLE_CYCLES-1; keep at least one bit.
  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [ID_W-1:0] LAST_ID     = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RESPOND} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [ID_W-1:0]   id_lat;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic [DATA_W-1:0] sel_data;
  logic [SC_W-1:0]   settle_cnt;

  // Round-robin search: first valid index at or above the pointer, else the
  // lowest valid index (which is then below the pointer, i.e. wrapped).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) >= ptr)) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    ptr_nxt = (winner == LAST_ID) ? '0 : winner + 1'b1;
  end

  // Operand mux selecting the winner's data slice.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; RESPOND always returns to IDLE before any new grant.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)              state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == '0)   state_nxt = RESPOND;
      RESPOND: if (rsp_ready)          state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Outputs: grant is combinational from request/state/pointer, busy from state.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && found) req_ready = NUM_REQ'(1) << winner;
    busy = (state != IDLE);
  end

  // Operand, pointer, settle counter, response and completion counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr          <= '0;
      id_lat       <= '0;
      settle_cnt   <= '0;
      eval_operand <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= 1'b0;
      done_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            eval_operand <= sel_data;
            id_lat       <= winner;
            settle_cnt   <= SETTLE_LOAD;
            ptr          <= ptr_nxt;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            rsp_result <= eval_result;
            rsp_id     <= id_lat;
            rsp_valid  <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            done_count <= done_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chain_eval_sched.sv
// Testbench for chain_eval_sched: scoreboarded round-robin scheduler checks.
// A second instance with a 2-bit completion counter runs the same stimulus.
`timescale 1ns/1ps
module tb_chain_eval_sched;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int SC = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic             rsp_ready;
  logic [NR-1:0]    req_ready,    req_ready_w;
  logic [DW-1:0]    eval_operand, eval_operand_w;
  logic             eval_result,  eval_result_w;
  logic             rsp_valid,    rsp_valid_w;
  logic [IW-1:0]    rsp_id,       rsp_id_w;
  logic             rsp_result,   rsp_result_w;
  logic             busy,         busy_w;
  logic [15:0]      done_count;
  logic [1:0]       done_count_w;

  typedef struct {
    logic [IW-1:0] id;
    logic          res;
    int            due;
  } exp_t;
  exp_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mdone  = 0;
  logic [DW-1:0] dv [NR];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain evaluator model: XOR-reduce of the operand, SC-1 register stages.
  logic [SC-2:0] dl, dl_w;
  always @(posedge clk) begin
    dl   <= {dl[SC-3:0],   ^eval_operand};
    dl_w <= {dl_w[SC-3:0], ^eval_operand_w};
  end
  assign eval_result   = dl[SC-2];
  assign eval_result_w = dl_w[SC-2];

  chain_eval_sched #(.NUM_REQ(NR), .DATA_W(DW), .SETTLE_CYCLES(SC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .eval_operand(eval_operand), .eval_result(eval_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_ready(rsp_ready), .busy(busy), .done_count(done_count));

  chain_eval_sched #(.NUM_REQ(NR), .DATA_W(DW), .SETTLE_CYCLES(SC), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_w), .eval_operand(eval_operand_w), .eval_result(eval_result_w),
    .rsp_valid(rsp_valid_w), .rsp_id(rsp_id_w), .rsp_result(rsp_result_w),
    .rsp_ready(rsp_ready), .busy(busy_w), .done_count(done_count_w));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data();
    dv[0] = 32'h0000_0001;
    dv[1] = 32'h0000_0300;
    dv[2] = 32'h0001_0000;
    dv[3] = 32'h0300_0000;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = dv[i];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0; req_data = {4{32'h5555_AAAA}};
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (req_ready !== 4'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold: req_ready=%b busy=%b required 0000/0", req_ready, busy);
      end
    end
    req_valid = '0;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_result, busy, req_ready} !== 9'b0) begin
      n_fail++; $display("FAIL reset_outs: v=%b id=%0d r=%b busy=%b rdy=%b required all 0",
                         rsp_valid, rsp_id, rsp_result, busy, req_ready);
    end
    n_cmp++;
    if (eval_operand !== 32'h0 || done_count !== 16'h0) begin
      n_fail++; $display("FAIL reset_regs: operand=%h done=%0d required 0/0", eval_operand, done_count);
    end
    n_cmp++;
    if ({rsp_valid_w, rsp_id_w, rsp_result_w, busy_w, req_ready_w, done_count_w} !== 11'b0 ||
        eval_operand_w !== 32'h0) begin
      n_fail++; $display("FAIL reset_wrap_inst: v=%b id=%0d done=%0d operand=%h required 0",
                         rsp_valid_w, rsp_id_w, done_count_w, eval_operand_w);
    end
    mdone = 0;
    sb.delete();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    exp_t e;
    d = 32'hDEADBEEF;
    req_data = '0;
    req_data[2*DW +: DW] = d;
    req_valid = 4'b0100; rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_grant: req_ready=%b required 0100", req_ready);
    end
    sb.push_back('{2'd2, ^d, cyc + 5});
    tick();
    req_valid = '0;
    #1;
    n_cmp++;
    if (eval_operand !== d || busy !== 1'b1 || req_ready !== 4'b0) begin
      n_fail++; $display("FAIL single_e0: operand=%h busy=%b rdy=%b required %h/1/0000",
                         eval_operand, busy, req_ready, d);
    end
    for (int k = 0; k < 12 && rsp_valid !== 1'b1; k++) tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL single_timeout: rsp_valid=%b required 1", rsp_valid);
    end else begin
      e = sb.pop_front();
      if (cyc !== e.due || rsp_id !== e.id || rsp_result !== e.res) begin
        n_fail++; $display("FAIL single_rsp: cyc=%0d id=%0d res=%b required %0d/%0d/%b",
                           cyc, rsp_id, rsp_result, e.due, e.id, e.res);
      end
    end
    rsp_ready = 1'b1;
    tick();
    mdone++;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_count !== 16'(mdone)) begin
      n_fail++; $display("FAIL single_done: v=%b busy=%b done=%0d required 0/0/%0d",
                         rsp_valid, busy, done_count, mdone);
    end
  endtask

  task automatic test_fairness();
    int order [6];
    int grants, resps, last_g, w;
    exp_t e;
    order = '{0, 1, 2, 3, 0, 1};
    grants = 0; resps = 0; last_g = -1;
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    tick();
    rst_n = 1'b1; mdone = 0; sb.delete();
    set_data();
    req_valid = 4'hF;
    for (int c = 0; c < 100 && (grants < 6 || resps < 6); c++) begin
      if (rsp_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL fair_spurious_rsp: id=%0d required no response", rsp_id);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.due || rsp_id !== e.id || rsp_result !== e.res) begin
            n_fail++; $display("FAIL fair_rsp: cyc=%0d id=%0d res=%b required %0d/%0d/%b",
                               cyc, rsp_id, rsp_result, e.due, e.id, e.res);
          end
        end
        resps++; mdone++;
      end
      #1;
      if (req_ready !== 4'b0 && grants < 6) begin
        w = order[grants];
        n_cmp++;
        if (req_ready !== (4'b1 << w)) begin
          n_fail++; $display("FAIL fair_grant%0d: req_ready=%b required %b", grants, req_ready, 4'b1 << w);
        end
        if (last_g >= 0) begin
          n_cmp++;
          if (cyc - last_g !== 6) begin
            n_fail++; $display("FAIL fair_gap: gap=%0d required 6", cyc - last_g);
          end
        end
        last_g = cyc;
        sb.push_back('{IW'(w), ^dv[w], cyc + 5});
        grants++;
      end
      tick();
      if (grants == 6) req_valid = '0;
    end
    n_cmp++;
    if (grants != 6 || resps != 6) begin
      n_fail++; $display("FAIL fair_count: grants=%0d resps=%0d required 6/6", grants, resps);
    end
    #1;
    n_cmp++;
    if (done_count !== 16'd6 || done_count_w !== 2'd2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL fair_done: done=%0d wrap=%0d busy=%b required 6/2/0",
                         done_count, done_count_w, busy);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    req_valid = 4'b0010; rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_grant: req_ready=%b required 0010", req_ready);
    end
    sb.push_back('{2'd1, ^dv[1], cyc + 5});
    tick();
    req_valid = 4'b1000;
    for (int k = 0; k < 12 && rsp_valid !== 1'b1; k++) tick();
    e = sb.pop_front();
    n_cmp++;
    if (rsp_valid !== 1'b1 || cyc !== e.due || rsp_id !== e.id || rsp_result !== e.res) begin
      n_fail++; $display("FAIL bp_rsp: v=%b cyc=%0d id=%0d res=%b required 1/%0d/%0d/%b",
                         rsp_valid, cyc, rsp_id, rsp_result, e.due, e.id, e.res);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res ||
          req_ready !== 4'b0 || eval_operand !== dv[1]) begin
        n_fail++; $display("FAIL bp_hold%0d: v=%b id=%0d res=%b rdy=%b operand=%h required 1/%0d/%b/0000/%h",
                           k, rsp_valid, rsp_id, rsp_result, req_ready, eval_operand, e.id, e.res, dv[1]);
      end
    end
    rsp_ready = 1'b1;
    tick();
    mdone++;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b1000 || done_count !== 16'(mdone)) begin
      n_fail++; $display("FAIL bp_release: v=%b busy=%b rdy=%b done=%0d required 0/0/1000/%0d",
                         rsp_valid, busy, req_ready, done_count, mdone);
    end
    sb.push_back('{2'd3, ^dv[3], cyc + 5});
    tick();
    req_valid = '0;
    for (int k = 0; k < 12 && rsp_valid !== 1'b1; k++) tick();
    e = sb.pop_front();
    n_cmp++;
    if (rsp_valid !== 1'b1 || cyc !== e.due || rsp_id !== e.id || rsp_result !== e.res) begin
      n_fail++; $display("FAIL bp_next_rsp: v=%b cyc=%0d id=%0d res=%b required 1/%0d/%0d/%b",
                         rsp_valid, cyc, rsp_id, rsp_result, e.due, e.id, e.res);
    end
    tick();
    mdone++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    req_valid = 4'b0100; rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL mid_grant: req_ready=%b required 0100", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mdone = 0;
    n_cmp++;
    if (busy !== 1'b0 || done_count !== 16'h0 || eval_operand !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: busy=%b done=%0d operand=%h required 0/0/0",
                         busy, done_count, eval_operand);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_no_rsp%0d: rsp_valid=%b required 0", k, rsp_valid);
      end
    end
    req_valid = 4'b1010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL mid_ptr_zero: req_ready=%b required 0010", req_ready);
    end
    sb.push_back('{2'd1, ^dv[1], cyc + 5});
    tick();
    req_valid = 4'b1000;
    for (int k = 0; k < 12 && rsp_valid !== 1'b1; k++) tick();
    e = sb.pop_front();
    n_cmp++;
    if (rsp_valid !== 1'b1 || cyc !== e.due || rsp_id !== e.id || rsp_result !== e.res) begin
      n_fail++; $display("FAIL mid_rsp1: v=%b cyc=%0d id=%0d res=%b required 1/%0d/%0d/%b",
                         rsp_valid, cyc, rsp_id, rsp_result, e.due, e.id, e.res);
    end
    tick();
    mdone++;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL mid_grant3: req_ready=%b required 1000", req_ready);
    end
    sb.push_back('{2'd3, ^dv[3], cyc + 5});
    tick();
    req_valid = '0;
    for (int k = 0; k < 12 && rsp_valid !== 1'b1; k++) tick();
    e = sb.pop_front();
    n_cmp++;
    if (rsp_valid !== 1'b1 || cyc !== e.due || rsp_id !== e.id || rsp_result !== e.res) begin
      n_fail++; $display("FAIL mid_rsp3: v=%b cyc=%0d id=%0d res=%b required 1/%0d/%0d/%b",
                         rsp_valid, cyc, rsp_id, rsp_result, e.due, e.id, e.res);
    end
    tick();
    mdone++;
    n_cmp++;
    if (done_count !== 16'(mdone)) begin
      n_fail++; $display("FAIL mid_done: done=%0d required %0d", done_count, mdone);
    end
  endtask

  task automatic test_counter_wrap();
    int seq [5];
    logic [DW-1:0] d;
    int idx;
    exp_t e;
    seq = '{1, 2, 3, 0, 1};
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    tick();
    rst_n = 1'b1; mdone = 0; sb.delete();
    for (int op = 0; op < 5; op++) begin
      idx = (op * 3) % NR;
      d = (op % 2 == 1) ? (32'h3 << (op * 4)) : (32'h1 << (op * 4));
      req_data = '0;
      req_data[idx*DW +: DW] = d;
      req_valid = 4'b1 << idx;
      #1;
      n_cmp++;
      if (req_ready !== (4'b1 << idx)) begin
        n_fail++; $display("FAIL wrap_grant%0d: req_ready=%b required %b", op, req_ready, 4'b1 << idx);
      end
      sb.push_back('{IW'(idx), ^d, cyc + 5});
      tick();
      req_valid = '0;
      for (int k = 0; k < 12 && rsp_valid !== 1'b1; k++) tick();
      e = sb.pop_front();
      n_cmp++;
      if (rsp_valid !== 1'b1 || cyc !== e.due || rsp_id !== e.id || rsp_result !== e.res) begin
        n_fail++; $display("FAIL wrap_rsp%0d: v=%b cyc=%0d id=%0d res=%b required 1/%0d/%0d/%b",
                           op, rsp_valid, cyc, rsp_id, rsp_result, e.due, e.id, e.res);
      end
      tick();
      mdone++;
      n_cmp++;
      if (done_count_w !== 2'(seq[op]) || done_count !== 16'(mdone)) begin
        n_fail++; $display("FAIL wrap_count%0d: wrap=%0d done=%0d required %0d/%0d",
                           op, done_count_w, done_count, seq[op], mdone);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
